// File: rtl/tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
// Line levels are encoded as {dp, dm}.
package tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_STUFF   = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
    } tx_state_t;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int STUFF_LIMIT_DEF  = 6;
    localparam int EOP_SE0_BITS_DEF = 2;

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI line register: a 0 bit toggles J<->K, a 1 bit holds the level.
// SE0 and J can be forced for end-of-packet; forcing J also re-arms the
// NRZI reference so the next packet starts from J.
module nrzi_encoder
    import tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic bit_en_i,
    input  logic force_se0_i,
    input  logic force_j_i,
    output logic dp_o,
    output logic dm_o
);

    logic [1:0] line_q;
    logic       lvl_j_q;   // 1 = current NRZI level is J
    logic       lvl_j_d;

    // Next NRZI level for the bit being emitted
    always_comb begin
        lvl_j_d = bit_i ? lvl_j_q : ~lvl_j_q;
    end

    // Line register: force requests win over data bits
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q  <= LINE_J;
            lvl_j_q <= 1'b1;
        end else if (force_j_i) begin
            line_q  <= LINE_J;
            lvl_j_q <= 1'b1;
        end else if (force_se0_i) begin
            line_q  <= LINE_SE0;
        end else if (bit_en_i) begin
            lvl_j_q <= lvl_j_d;
            line_q  <= lvl_j_d ? LINE_J : LINE_K;
        end
    end

    assign dp_o = line_q[1];
    assign dm_o = line_q[0];

endmodule

// File: rtl/tx_serializer.sv
// USB transmit serializer: 1-byte holding buffer, LSB-first shifter,
// optional bit stuffing, NRZI line drive and EOP (SE0 x N, J).
// Bit stuffing is built only when TX_BIT_STUFF_EN is defined; without it
// the STUFF state and ones counter are absent and stuff_hold is tied 0.
module tx_serializer
    import tx_pkg::*;
#(
    parameter int EOP_SE0_BITS = EOP_SE0_BITS_DEF
`ifdef TX_BIT_STUFF_EN
    ,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_strobe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       send_eop,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       stuff_hold,
    output logic       busy,
    output logic       eop_done,
    output logic       underrun
);

    localparam int SW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
    localparam logic [SW-1:0] SE0_LAST = SW'(EOP_SE0_BITS - 1);

    tx_state_t     state_q;
    logic [7:0]    buf_q;
    logic          buf_full_q;
    logic [7:0]    sr_q;
    logic [2:0]    bit_idx_q;
    logic          eop_pend_q;
    logic [SW-1:0] se0_cnt_q;
    logic          underrun_q;
    logic          eop_done_q;

`ifdef TX_BIT_STUFF_EN
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [OW-1:0] ONES_LAST = OW'(STUFF_LIMIT - 1);
    logic [OW-1:0] ones_q;
    logic          byte_end_q;   // stuff bit was inserted after bit 7
`endif

    logic accept;
    logic strobe_shift;
    logic strobe_stuff;
    logic stuff_next;
    logic boundary;
    logic eop_set;

    // Handshake, strobe qualification and byte-boundary detection
    always_comb begin
        accept       = tx_valid && !buf_full_q;
        strobe_shift = shift_strobe && (state_q == ST_SHIFT);
        strobe_stuff = shift_strobe && (state_q == ST_STUFF);
        stuff_next   = 1'b0;
        boundary     = strobe_shift && (bit_idx_q == 3'd7);
`ifdef TX_BIT_STUFF_EN
        // A 6th one at bit 7 defers the boundary until after the stuff bit
        stuff_next   = strobe_shift && sr_q[0] && (ones_q == ONES_LAST);
        boundary     = (strobe_shift && (bit_idx_q == 3'd7) && !stuff_next)
                    || (strobe_stuff && byte_end_q);
`endif
        // A byte offered in the same cycle counts as an active packet
        eop_set      = send_eop && !((state_q == ST_IDLE) && !buf_full_q && !tx_valid);
    end

    // Holding buffer: filled on handshake, drained into the shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else if (accept) begin
            buf_q      <= tx_data;
            buf_full_q <= 1'b1;
        end else if (buf_full_q && ((state_q == ST_IDLE) || boundary)) begin
            buf_full_q <= 1'b0;
        end
    end

    // EOP request latch, consumed when the packet ends
    always_ff @(posedge clk) begin
        if (rst) begin
            eop_pend_q <= 1'b0;
        end else if (boundary && !buf_full_q) begin
            eop_pend_q <= 1'b0;
        end else if (eop_set) begin
            eop_pend_q <= 1'b1;
        end
    end

    // Packet state machine with registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            bit_idx_q  <= '0;
            se0_cnt_q  <= '0;
            underrun_q <= 1'b0;
            eop_done_q <= 1'b0;
`ifdef TX_BIT_STUFF_EN
            ones_q     <= '0;
            byte_end_q <= 1'b0;
`endif
        end else begin
            underrun_q <= 1'b0;
            eop_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (buf_full_q) begin
                        sr_q      <= buf_q;
                        bit_idx_q <= '0;
                        state_q   <= ST_SHIFT;
`ifdef TX_BIT_STUFF_EN
                        ones_q    <= '0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (shift_strobe) begin
                        sr_q      <= {1'b0, sr_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
`ifdef TX_BIT_STUFF_EN
                        ones_q    <= sr_q[0] ? ones_q + OW'(1) : '0;
                        if (stuff_next) begin
                            state_q    <= ST_STUFF;
                            byte_end_q <= (bit_idx_q == 3'd7);
                        end
`endif
                    end
                end
                ST_STUFF: begin
                    if (shift_strobe) begin
                        state_q <= ST_SHIFT;
`ifdef TX_BIT_STUFF_EN
                        ones_q  <= '0;
`endif
                    end
                end
                ST_EOP_SE0: begin
                    if (shift_strobe) begin
                        if (se0_cnt_q == SE0_LAST) begin
                            se0_cnt_q <= '0;
                            state_q   <= ST_EOP_J;
                        end else begin
                            se0_cnt_q <= se0_cnt_q + SW'(1);
                        end
                    end
                end
                ST_EOP_J: begin
                    if (shift_strobe) begin
                        eop_done_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Byte boundary: reload seamlessly, else end the packet
            if (boundary) begin
                if (buf_full_q) begin
                    sr_q      <= buf_q;
                    bit_idx_q <= '0;
                    state_q   <= ST_SHIFT;
                end else begin
                    se0_cnt_q  <= '0;
                    state_q    <= ST_EOP_SE0;
                    underrun_q <= !eop_pend_q;
                end
            end
        end
    end

    nrzi_encoder u_nrzi (
        .clk         (clk),
        .rst         (rst),
        .bit_i       (strobe_stuff ? 1'b0 : sr_q[0]),
        .bit_en_i    (strobe_shift || strobe_stuff),
        .force_se0_i (shift_strobe && (state_q == ST_EOP_SE0)),
        .force_j_i   (shift_strobe && (state_q == ST_EOP_J)),
        .dp_o        (dplus_out),
        .dm_o        (dminus_out)
    );

    assign tx_ready   = !buf_full_q;
    assign busy       = (state_q != ST_IDLE);
    assign eop_done   = eop_done_q;
    assign underrun   = underrun_q;
    assign stuff_hold = strobe_stuff;

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: per-strobe expected line sequence derived from
// the byte list (stuffing, NRZI, EOP), checked every cycle of a packet.
module tb_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       shift_strobe = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       send_eop = 1'b0;
    logic       tx_ready, dplus_out, dminus_out, stuff_hold, busy, eop_done, underrun;

`ifdef TX_BIT_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif
    localparam int LIMIT = 6;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    int tests = 0;
    int fails = 0;
    int sh_cnt = 0;

    logic [1:0] e_line[$];
    bit         e_stuff[$];
    bit         e_bend[$];
    logic [1:0] got_line[$];

    tx_serializer dut (
        .clk(clk), .rst(rst), .shift_strobe(shift_strobe), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .send_eop(send_eop),
        .dplus_out(dplus_out), .dminus_out(dminus_out), .stuff_hold(stuff_hold),
        .busy(busy), .eop_done(eop_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (stuff_hold) sh_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-strobe line values from the byte list
    task automatic build_model(input logic [7:0] bytes[$]);
        int         ones = 0;
        logic [1:0] lvl = J;
        logic       b;
        e_line.delete(); e_stuff.delete(); e_bend.delete();
        for (int n = 0; n < bytes.size(); n++) begin
            for (int i = 0; i < 8; i++) begin
                b = bytes[n][i];
                if (!b) lvl = ~lvl;
                e_line.push_back(lvl); e_stuff.push_back(1'b0); e_bend.push_back(1'b0);
                ones = b ? ones + 1 : 0;
                if (STUFF_ON && ones == LIMIT) begin
                    lvl = ~lvl;
                    e_line.push_back(lvl); e_stuff.push_back(1'b1); e_bend.push_back(1'b0);
                    ones = 0;
                end
                if (i == 7) e_bend[e_bend.size()-1] = 1'b1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            e_line.push_back(SE0); e_stuff.push_back(1'b0); e_bend.push_back(1'b0);
        end
        e_line.push_back(J); e_stuff.push_back(1'b0); e_bend.push_back(1'b0);
    endtask

    task automatic run_packet(input logic [7:0] bytes[$], input bit eop, input int abort_at);
        int last_bend = 0;
        build_model(bytes);
        got_line.delete();
        for (int k = 0; k < e_bend.size(); k++) if (e_bend[k]) last_bend = k;
        fork
            begin : feeder
                for (int n = 0; n < bytes.size(); n++) begin
                    bit r;
                    int w = 0;
                    tx_data  = bytes[n];
                    tx_valid = 1'b1;
                    send_eop = eop && (n == bytes.size() - 1);
                    forever begin
                        r = tx_ready;
                        @(posedge clk);
                        if (r) break;
                        @(negedge clk);
                        w++;
                        if (w > 400) begin
                            chk("accept_timeout", 32'(w), 32'(0));
                            break;
                        end
                    end
                    @(negedge clk);
                    tx_valid = 1'b0;
                    send_eop = 1'b0;
                end
            end
            begin : strober
                logic [1:0] cur = J;
                for (int k = 0; k < e_line.size(); k++) begin
                    int gap = (k == 0) ? 3 : $urandom_range(1, 3);
                    repeat (gap) begin
                        @(posedge clk); @(negedge clk);
                        chk("gap_line", {30'd0, dplus_out, dminus_out}, {30'd0, cur});
                        chk("gap_underrun", underrun, 0);
                        chk("gap_eop_done", eop_done, 0);
                        chk("gap_stuff_hold", stuff_hold, 0);
                    end
                    shift_strobe = 1'b1;
                    #1;
                    chk("stuff_hold", stuff_hold, e_stuff[k]);
                    @(posedge clk); @(negedge clk);
                    shift_strobe = 1'b0;
                    if (abort_at > 0 && k + 1 == abort_at) begin
                        rst = 1'b1;
                        @(posedge clk); @(negedge clk);
                        rst = 1'b0;
                        chk("rst_dplus", dplus_out, 1);
                        chk("rst_dminus", dminus_out, 0);
                        chk("rst_busy", busy, 0);
                        chk("rst_tx_ready", tx_ready, 1);
                        chk("rst_underrun", underrun, 0);
                        break;
                    end
                    cur = e_line[k];
                    got_line.push_back({dplus_out, dminus_out});
                    chk("line", {30'd0, dplus_out, dminus_out}, {30'd0, cur});
                    chk("underrun", underrun, (k == last_bend) && !eop);
                    chk("eop_done", eop_done, k == e_line.size() - 1);
                    chk("busy", busy, k != e_line.size() - 1);
                    if (e_bend[k]) chk("tx_ready_boundary", tx_ready, 1);
                end
            end
        join
    endtask

    initial begin
        logic [7:0] q[$];
        logic [1:0] pin[11];
        int         first_se0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dplus", dplus_out, 1);
        chk("reset_dminus", dminus_out, 0);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_eop_done", eop_done, 0);
        rst = 1'b0;

        // Idle: strobes alone must leave the line at J
        for (int i = 0; i < 20; i++) begin
            shift_strobe = 1'b1;
            @(posedge clk); @(negedge clk);
            shift_strobe = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("idle_line", {30'd0, dplus_out, dminus_out}, {30'd0, J});
            chk("idle_busy", busy, 0);
            chk("idle_tx_ready", tx_ready, 1);
        end

        // 0x80 with EOP, pinned against a hand-written line sequence
        q = '{8'h80};
        run_packet(q, 1'b1, 0);
        pin = '{K, J, K, J, K, J, K, K, SE0, SE0, J};
        chk("pin80_len", 32'(got_line.size()), 32'd11);
        for (int i = 0; i < 11 && i < got_line.size(); i++)
            chk("pin80_line", {30'd0, got_line[i]}, {30'd0, pin[i]});

        // Long run of ones across a byte boundary
        q = '{8'hFF, 8'h01};
        sh_cnt = 0;
        run_packet(q, 1'b1, 0);
        first_se0 = -1;
        for (int i = 0; i < got_line.size(); i++)
            if (first_se0 < 0 && got_line[i] == SE0) first_se0 = i;
        chk("ff01_bit_times", 32'(first_se0), STUFF_ON ? 32'd17 : 32'd16);
        chk("ff01_stuff_cycles", 32'(sh_cnt), STUFF_ON ? 32'd1 : 32'd0);

        // Back-to-back bytes, no gap bit
        q = '{8'h00, 8'h55, 8'hAA};
        run_packet(q, 1'b1, 0);
        chk("b2b_bit_times", 32'(got_line.size()), 32'd27);

        // Sixth one lands on bit 7: boundary after the stuff bit
        q = '{8'hFC, 8'h01};
        run_packet(q, 1'b1, 0);
        q = '{8'hFC};
        run_packet(q, 1'b0, 0);

        // Underrun forces EOP
        q = '{8'h3C};
        run_packet(q, 1'b0, 0);

        // Reset mid-packet, then a clean packet with a fresh ones count
        q = '{8'hA5};
        run_packet(q, 1'b1, 4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        q = '{8'h3F, 8'hFF};
        run_packet(q, 1'b1, 0);

        // Randomized packets
        for (int p = 0; p < 10; p++) begin
            int nb = $urandom_range(1, 3);
            q.delete();
            for (int b = 0; b < nb; b++) q.push_back(8'($urandom));
            run_packet(q, 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Downstream consumer of the transmit bit timer; sits between the tx byte source (FIFO / packet controller) and the bus drivers.
- Accepts bytes over a valid/ready handshake and shifts them LSB-first, one bit per timer shift_strobe.
- Applies USB bit stuffing and NRZI encoding, drives dplus_out/dminus_out, and appends EOP (SE0, SE0, J).
- Drives stuff_hold back to the timer so stuffed bits are not counted as data bits.

Parameters:
- STUFF_LIMIT, 6: consecutive 1 data bits after which one 0 is inserted.
- EOP_SE0_BITS, 2: SE0 bit times in EOP; J follows for 1 bit time.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- shift_strobe  in  1  one-cycle bit-time tick from tx timer
- tx_data  in  8  byte to send, LSB first
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding buffer empty; byte accepted when tx_valid && tx_ready
- send_eop  in  1  pulse: finish packet after last accepted byte
- dplus_out  out  1  D+ line level
- dminus_out  out  1  D- line level
- stuff_hold  out  1  high during the strobe cycle that emits a stuff bit
- busy  out  1  packet in progress (not IDLE)
- eop_done  out  1  one-cycle pulse when the EOP J bit ends
- underrun  out  1  one-cycle pulse: byte ended, no next byte, no EOP pending

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State returns to IDLE; holding buffer, shift register, ones count and eop_pending are cleared.
  - Outputs: dplus_out=1, dminus_out=0 (J); tx_ready=1; busy=0; stuff_hold=0; eop_done=0; underrun=0.
  - Applies mid-packet too; the line goes to J on the next edge, with no EOP.
- Holding buffer:
  - 1 byte; tx_ready = !buf_full.
  - Any cycle: tx_valid && tx_ready loads the buffer.
- send_eop: sets eop_pending, which is consumed by the EOP transition. Ignored in IDLE with the buffer empty.
- States: IDLE, SHIFT, STUFF, EOP_SE0, EOP_J.
  - IDLE: line J.
    - Buffer full moves the byte to the shift register, clears the ones count, goes to SHIFT.
    - Data is transmitted starting at the next shift_strobe.
  - SHIFT, on shift_strobe:
    - Emits sr[0] and shifts; bit_idx increments 0..7.
    - Data 1 increments ones; data 0 clears it.
    - If ones reaches STUFF_LIMIT, go to STUFF.
    - After bit 7: buffer full reloads the shift register (seamless, no gap bit) and frees the buffer.
    - Otherwise eop_pending goes to EOP_SE0.
    - Otherwise underrun pulses and the block goes to EOP_SE0 (forced EOP).
  - STUFF, on shift_strobe:
    - Emits a 0 bit, clears ones; stuff_hold=1 that cycle.
    - Returns to SHIFT; any byte-boundary action deferred by the 6th one is taken now.
  - EOP_SE0: drives dplus=dminus=0 for EOP_SE0_BITS strobes, then goes to EOP_J.
  - EOP_J: J for 1 strobe; eop_done pulses; goes to IDLE; NRZI state resets to J.
- NRZI:
  - Data 0 toggles the line (J<->K); data 1 holds it.
  - J=(1,0), K=(0,1).
- Line outputs are registered and change on the clk edge after the strobe cycle, a 1-cycle latency.
- busy = state != IDLE.
- Simultaneous events:
  - tx_valid and send_eop in the same cycle: the byte is sent, then EOP.
  - A strobe coincident with buffer load: the loaded byte is visible at that same bit-7 boundary only if it was already registered before the strobe cycle.
- The strobe never arrives in consecutive cycles; no handling is required for that case.

Optional Feature:
- Macro: TX_BIT_STUFF_EN.
- Defined: stuffing exactly as above.
- Undefined:
  - STUFF state and ones counter are removed.
  - stuff_hold is tied 0.
  - Long runs of 1 are sent unstuffed (test/loopback builds).

Decomposition:
- Package tx_pkg:
  - tx_state_t enum.
  - Line-level constants LINE_J, LINE_K, LINE_SE0 (2-bit {dp,dm}).
  - Default STUFF_LIMIT and EOP_SE0_BITS.
- Sub-module nrzi_encoder holds the line register and takes bit, bit_en, force_se0, force_j.
- The state machine, buffer and stuffing stay in tx_serializer.

Test Plan:
- Idle after reset → dplus_out=1, dminus_out=0, tx_ready=1, busy=0 for 20 strobes.
- Send 0x80 then send_eop → line sequence K,J,K,J,K,J,K,K, then SE0,SE0,J; eop_done pulses once; busy falls.
- Send 0xFF,0x01 → a 0 is inserted after the 6th 1 (line toggles); stuff_hold is high for exactly one strobe cycle; 17 bit times total before EOP.
- Back-to-back 0x00,0x55,0xAA held valid → no gap bit between bytes; tx_ready drops after each accept and reasserts at each byte boundary.
- Single byte 0x3C with no send_eop → underrun pulses at the byte end; EOP is still produced.
- rst asserted at bit 4 of byte 0xA5 → next edge: J, busy=0, tx_ready=1; the next packet starts cleanly with ones count 0.
